// File: rtl/uart_rx_frontend_pkg.sv
// Shared constants, payload types and helpers for the UART RX front end.
// Optional feature macro: UART_RX_FRAC_BAUD_EN (fractional baud divisor).
package uart_rx_frontend_pkg;

  localparam int unsigned UART_DL_W     = 16;
  localparam int unsigned FRAC_W        = 4;
  localparam int unsigned FILT_W        = 3;
  localparam logic        UART_RX_IDLE  = 1'b1;
  localparam logic [2:0]  UART_FILT_RST = 3'b111;

  // Filtered line state handed to the receiver.
  typedef struct packed {
    logic srx_filt;
    logic rx_glitch;
  } filt_status_t;

  function automatic logic maj3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

  function automatic logic unanimous3(input logic [2:0] w);
    return (w == 3'b000) || (w == 3'b111);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Pad-side and receiver-side signals of one UART RX front-end channel.
// frac exists only when UART_RX_FRAC_BAUD_EN is defined.
interface uart_rx_frontend_if
  import uart_rx_frontend_pkg::*;
#(
  parameter int unsigned DIV_W = UART_DL_W
);

  logic             rx_en;
  logic [DIV_W-1:0] dl;
  logic             dl_we;
`ifdef UART_RX_FRAC_BAUD_EN
  logic [FRAC_W-1:0] frac;
`endif
  logic             srx_raw;
  logic             enable;
  logic             srx_filt;
  logic             rx_glitch;

  modport master (
`ifdef UART_RX_FRAC_BAUD_EN
    output frac,
`endif
    output rx_en, dl, dl_we, srx_raw,
    input  enable, srx_filt, rx_glitch
  );

  modport slave (
`ifdef UART_RX_FRAC_BAUD_EN
    input  frac,
`endif
    input  rx_en, dl, dl_we, srx_raw,
    output enable, srx_filt, rx_glitch
  );

endinterface

// File: rtl/uart_rx_sync_filter.sv
// Pad synchroniser plus 3-sample majority filter advanced on each 16x tick.
module uart_rx_sync_filter
  import uart_rx_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic srx_raw,
  output logic srx_filt,
  output logic rx_glitch
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      win_q, win_d;
  filt_status_t           st_q, st_d;

  // Next-state: sync chain always shifts, window only on ticks.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], srx_raw};
    win_d        = win_q;
    st_d         = st_q;
    st_d.rx_glitch = 1'b0;
    if (tick) begin
      win_d          = {win_q[FILT_W-2:0], sync_q[SYNC_STAGES-1]};
      st_d.srx_filt  = maj3(win_d);
      st_d.rx_glitch = ~unanimous3(win_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      win_q  <= UART_FILT_RST;
      st_q   <= '{srx_filt: UART_RX_IDLE, rx_glitch: 1'b0};
    end else begin
      sync_q <= sync_d;
      win_q  <= win_d;
      st_q   <= st_d;
    end
  end

  assign srx_filt  = st_q.srx_filt;
  assign rx_glitch = st_q.rx_glitch;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART RX front end: 16x baud tick divisor and filtered RX line for uart_receiver.
// Define UART_RX_FRAC_BAUD_EN to add the fractional (sixteenths) divisor.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int unsigned DIV_W       = UART_DL_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  uart_rx_frontend_if.slave bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             enable_q, enable_d;
  logic             carry;

`ifdef UART_RX_FRAC_BAUD_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, bus.frac};
  assign carry   = acc_sum[FRAC_W];
`else
  assign carry = 1'b0;
`endif

  // Divisor next-state: reload beats freeze beats stop beats count.
  always_comb begin
    cnt_d    = cnt_q;
    enable_d = 1'b0;
`ifdef UART_RX_FRAC_BAUD_EN
    acc_d    = acc_q;
`endif
    if (bus.dl_we) begin
      cnt_d = (bus.dl == '0) ? '0 : bus.dl - DIV_W'(1);
`ifdef UART_RX_FRAC_BAUD_EN
      acc_d = '0;
`endif
    end else if (!bus.rx_en) begin
      cnt_d = cnt_q;
    end else if (bus.dl == '0) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      enable_d = 1'b1;
      // A fractional carry stretches the next period by one clock.
      cnt_d    = carry ? bus.dl : bus.dl - DIV_W'(1);
`ifdef UART_RX_FRAC_BAUD_EN
      acc_d    = acc_sum[FRAC_W-1:0];
`endif
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      enable_q <= 1'b0;
`ifdef UART_RX_FRAC_BAUD_EN
      acc_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
`ifdef UART_RX_FRAC_BAUD_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign bus.enable = enable_q;

  uart_rx_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .tick      (enable_q & bus.rx_en),
    .srx_raw   (bus.srx_raw),
    .srx_filt  (bus.srx_filt),
    .rx_glitch (bus.rx_glitch)
  );

endmodule
